// File: rtl/parallel_adder_pkg.sv
// Shared constants and helpers for the registered ripple-carry adder tile.
// Imported by the full-adder cell and the top-level adder.
package parallel_adder_pkg;

    localparam int DEFAULT_WIDTH = 3;
    localparam int MIN_WIDTH     = 1;
    localparam int MAX_WIDTH     = 16;

    // Width of the internal {carry, sum} result vector.
    function automatic int sum_w(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/parallel_adder_full_adder.sv
// One-bit combinational full-adder cell.
// Forms one link of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/parallel_adder.sv
// Registered ripple-carry adder: {Cout, Sum} <= A + B + Cin.
// Sync active-high reset clears both output registers.
module parallel_adder
    import parallel_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int SUM_W = sum_w(WIDTH);

    // carry[i] enters bit i; carry[WIDTH] leaves the top bit.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s_comb;
    logic [SUM_W-1:0] result;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (s_comb[i]),
            .co (carry[i+1])
        );
    end

    assign result = {carry[WIDTH], s_comb};

    always_ff @(posedge clk) begin
        if (rst) begin
            Sum  <= '0;
            Cout <= 1'b0;
        end else begin
            Sum  <= result[WIDTH-1:0];
            Cout <= result[SUM_W-1];
        end
    end

endmodule

// File: tb/tb_parallel_adder.sv
// Randomized/directed bench for parallel_adder at WIDTH 3, 1 and 8.
// Reference model is plain integer addition of A+B+Cin.
module tb_parallel_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] a3, b3, s3;
    logic       c3, co3;
    logic [0:0] a1, b1, s1;
    logic       c1, co1;
    logic [7:0] a8, b8, s8;
    logic       c8, co8;

    int tests = 0;
    int fails = 0;

    parallel_adder #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .A(a3), .B(b3), .Cin(c3), .Sum(s3), .Cout(co3)
    );
    parallel_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .Sum(s1), .Cout(co1)
    );
    parallel_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .Sum(s8), .Cout(co8)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] golden(input int w, input int a,
                                           input int b, input int c,
                                           input bit r);
        int full;
        if (r) return 32'd0;
        full = a + b + c;
        return 32'(full % (1 << (w + 1)));
    endfunction

    // Expectation is taken from the inputs present at the coming edge.
    task automatic tick(input string tag);
        logic [31:0] e3, e1, e8;
        e3 = golden(3, int'(a3), int'(b3), int'(c3), rst);
        e1 = golden(1, int'(a1), int'(b1), int'(c1), rst);
        e8 = golden(8, int'(a8), int'(b8), int'(c8), rst);
        @(posedge clk);
        #1;
        check({tag, "/w3"}, 32'({co3, s3}), e3);
        check({tag, "/w1"}, 32'({co1, s1}), e1);
        check({tag, "/w8"}, 32'({co8, s8}), e8);
    endtask

    task automatic rand_all();
        a3 = 3'($urandom); b3 = 3'($urandom); c3 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        a3 = 3'd7; b3 = 3'd7; c3 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a8 = 8'hff; b8 = 8'hff; c8 = 1'b1;
        tick("reset0");
        tick("reset1");
        check("reset_sum", 32'(s3), 32'd0);
        check("reset_cout", 32'(co3), 32'd0);
        rst = 1'b0;
        tick("max_add");
        check("max_sum", 32'(s3), 32'd7);
        check("max_cout", 32'(co3), 32'd1);

        a3 = 3'd3; b3 = 3'd2; c3 = 1'b0;
        tick("add_3_2");
        check("add_3_2_sum", 32'(s3), 32'd5);
        a3 = 3'd1; b3 = 3'd1; c3 = 1'b1;
        tick("add_1_1_1");
        check("add_1_1_1_sum", 32'(s3), 32'd3);

        a3 = 3'd5; b3 = 3'd4; c3 = 1'b0;
        tick("wrap_5_4");
        check("wrap_5_4_cout", 32'(co3), 32'd1);
        a3 = 3'd7; b3 = 3'd0; c3 = 1'b1;
        tick("ripple_7_0_1");
        check("ripple_sum", 32'(s3), 32'd0);

        a3 = 3'd0; b3 = 3'd0; c3 = 1'b0;
        tick("zero");

        a8 = 8'd255; b8 = 8'd1; c8 = 1'b0;
        tick("w8_255_1");
        check("w8_wrap_sum", 32'(s8), 32'd0);
        check("w8_wrap_cout", 32'(co8), 32'd1);

        for (int i = 0; i < 128; i++) begin
            a3 = 3'(i >> 4);
            b3 = 3'(i >> 1);
            c3 = 1'(i);
            a1 = 1'(i >> 2);
            b1 = 1'(i >> 1);
            c1 = 1'(i);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            tick("exhaustive");
        end

        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 6; j++) begin
                rand_all();
                tick("stream");
            end
            rand_all();
            rst = 1'b1;
            tick("mid_reset");
            rst = 1'b0;
            rand_all();
            tick("post_reset");
        end

        for (int i = 0; i < 200; i++) begin
            rand_all();
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
